fifo_ram_ctrl: RTL and testbench
================================

# fifo_ram_ctrl

Single-clock controller that sequences the `dualInputRamFifo` storage (32-entry, 32-bit, 6-bit wrap-bit pointers). It shares the RAM write port between two producers with a round-robin arbiter. It serves one consumer and owns the write/read pointers, enables and full/empty/count status. It sits between the producer/consumer logic and the RAM instance, and replaces pointer generation done by hand in benches.

## Interface

Parameters:
- `ADDR_W`, 5: RAM address width; depth = 2**ADDR_W = 32.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of pointers; does not reset arbiter priority.
- `req0`, `req1`  in  1  producer write requests.
- `wd0`, `wd1`  in  DATA_W  producer write data.
- `gnt0`, `gnt1`  out  1  write accepted this cycle (combinational).
- `pop`  in  1  consumer read request.
- `rvalid`  out  1  RAM `rd` is valid this cycle (registered).
- `wptr`  out  ADDR_W+1  to RAM `wptr`; MSB is the wrap bit.
- `rptr`  out  ADDR_W+1  to RAM `rptr`; MSB is the wrap bit.
- `writeEnable`  out  1  to RAM.
- `readEnable`  out  1  to RAM.
- `wd`  out  DATA_W  to RAM write data; the muxed granted producer data.
- `full`, `empty`  out  1  status from registered pointers.
- `count`  out  ADDR_W+1  occupancy, 0..32.

## Operation

- `empty` = (`wptr` == `rptr`).
- `full` = MSBs differ and low ADDR_W bits are equal.
- `count` = `wptr` - `rptr` modulo 2**(ADDR_W+1).
- Write arbitration:
  - No grant is issued when `full`, `flush` or `reset` is high.
  - One requester only: it is granted.
  - Both requesting: grant the one not granted last. Register `last_gnt` updates on every grant.
  - `last_gnt` resets to 1, so `req0` wins the first tie.
- `writeEnable` = `gnt0` | `gnt1`.
- `wd` = `wd0` when `gnt0`, else `wd1`. When no grant, `wd` is don't-care; drive `wd0`.
- Read: `readEnable` = `pop` & ~`empty` & ~`flush`.
- Pointer updates: `wptr` increments on the edge after a grant. `rptr` increments on the edge after `readEnable`. Both wrap 63→0, toggling the MSB.
- Simultaneous write and read: both proceed; `count` is unchanged.
- Full and pop together: the read proceeds. The write is still blocked this cycle because `full` is computed from registered pointers.
- Empty and push together: the write proceeds. `pop` is ignored this cycle and `rvalid` stays 0 next cycle.
- Pops while empty and pushes while full are dropped silently. There is no error flag.
- `flush`: both pointers go to 0 next edge. `rvalid` of an already-issued read still asserts.
- `reset` mid-operation clears everything next edge. In-flight `rvalid` is suppressed.

## Timing

- Reset values:
  - `wptr` = `rptr` = 0, `count` = 0, `empty` = 1, `full` = 0, `rvalid` = 0, `last_gnt` = 1.
  - `gnt*`, `writeEnable`, `readEnable` = 0.
- Grant and enables are combinational from the current requests and registered pointers. There is zero-cycle handshake: a producer holds `req`/`wd` until it sees `gnt` high at a clock edge.
- The RAM samples `wptr`/`wd` on the edge where `writeEnable` = 1.
- The RAM read has one-cycle latency. `rvalid` = `readEnable` registered, so it is high exactly one cycle after the read and aligned with RAM `rd`.
- Sustained throughput: one write and one read per cycle.
- Status outputs update one edge after the causing event.

## Structure

- Package `fifo_ctrl_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults and `DEPTH` = 2**ADDR_W.
  - The pointer typedef `ptr_t` (ADDR_W+1 bits).
- Sub-module `rr_arb2` holds the 2-requester round-robin logic: inputs `req[1:0]` and `block`, output `gnt[1:0]`, internal `last_gnt` register.
- The top level instantiates `rr_arb2` and holds the pointer, status and `rvalid` logic.

## Test plan

- Reset, then `req0` alone for 32 cycles with `wd0` = 1..32:
  - 32 grants.
  - `wptr` steps 0→32 (MSB set), `full` = 1, `count` = 32.
  - 33rd request gets no grant.
- Both requesting continuously from reset:
  - Grants alternate 0,1,0,1…
  - RAM holds `wd0`/`wd1` interleaved.
- Fill with 1..32, then `pop` 32 cycles:
  - `rvalid` one cycle after each `readEnable`, with `rd` = 1..32.
  - `empty` = 1 after the last read.
  - `rptr` = 32.
- Pointer wrap (32 writes/reads ×3):
  - `wptr`/`rptr` pass 63→0.
  - Data is still in order.
  - `full`/`empty` are correct at each wrap.
- Simultaneous push and pop at `count` = 10 for 20 cycles: `count` stays 10 throughout. `full` at 32 with push and pop: only the read happens, and `count` goes to 31.
- Mid-stream checks:
  - `flush` at `count` = 7: next cycle `count` = 0, `empty` = 1, `last_gnt` kept.
  - `reset` issued the cycle after a read: no `rvalid`, all outputs at reset values.

Source files
------------

// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared defaults and types for the dual-producer FIFO RAM controller.
// Pointers carry one extra wrap bit above the RAM address.
package fifo_ctrl_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;

    typedef enum logic {
        GNT_P0 = 1'b0,
        GNT_P1 = 1'b1
    } gnt_sel_e;

endpackage

// File: rtl/fifo_ram_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter for the shared RAM write port.
// On a tie the requester not granted last wins; priority survives flush.
module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] gnt
);

    gnt_sel_e last_gnt_q;
    gnt_sel_e last_gnt_d;

    always_comb begin
        gnt        = '0;
        last_gnt_d = last_gnt_q;
        if (!block) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_gnt_q == GNT_P1) ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
        if (gnt[0]) begin
            last_gnt_d = GNT_P0;
        end else if (gnt[1]) begin
            last_gnt_d = GNT_P1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= GNT_P1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Pointer, status and read-valid sequencing for a 2-producer / 1-consumer
// FIFO built on an external single-clock RAM with one-cycle read latency.
module fifo_ram_ctrl #(
    parameter int unsigned ADDR_W = fifo_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W = fifo_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              pop,
    output logic              rvalid,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr,
    output logic              writeEnable,
    output logic              readEnable,
    output logic [DATA_W-1:0] wd,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      gnt;

    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign count = wptr_q - rptr_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1, req0}),
        .block (full | flush | reset),
        .gnt   (gnt)
    );

    assign gnt0        = gnt[0];
    assign gnt1        = gnt[1];
    assign writeEnable = gnt[0] | gnt[1];
    assign readEnable  = pop & ~empty & ~flush & ~reset;
    assign wd          = gnt[1] ? wd1 : wd0;
    assign wptr        = wptr_q;
    assign rptr        = rptr_q;

    // An in-flight read is dropped as soon as reset is seen, not one cycle later.
    assign rvalid = rvalid_q & ~reset;

    always_comb begin
        wptr_d   = wptr_q + {{ADDR_W{1'b0}}, writeEnable};
        rptr_d   = rptr_q + {{ADDR_W{1'b0}}, readEnable};
        rvalid_d = readEnable;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based FIFO model, with a behavioural RAM supplying rd.
module tb_fifo_ram_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset, flush, req0, req1, pop;
    logic [DW-1:0] wd0, wd1, wd;
    logic          gnt0, gnt1, rvalid, writeEnable, readEnable, full, empty;
    logic [AW:0]   wptr, rptr, count;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd;

    int unsigned   q[$];
    int unsigned   wp, rp;
    bit            last;
    bit            rv_pend;
    logic [DW-1:0] rd_exp;
    int            n_chk = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    fifo_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req0(req0), .req1(req1), .wd0(wd0), .wd1(wd1),
        .gnt0(gnt0), .gnt1(gnt1), .pop(pop), .rvalid(rvalid),
        .wptr(wptr), .rptr(rptr), .writeEnable(writeEnable),
        .readEnable(readEnable), .wd(wd), .full(full), .empty(empty),
        .count(count)
    );

    always @(posedge clk) begin
        if (writeEnable) mem[wptr[AW-1:0]] <= wd;
        rd <= mem[rptr[AW-1:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step(input bit r, input bit f, input bit r0, input bit r1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit p);
        int  g;
        bit  re, full_m, empty_m;
        @(negedge clk);
        reset = r; flush = f; req0 = r0; req1 = r1; wd0 = d0; wd1 = d1; pop = p;
        #1;
        full_m  = (q.size() == 32);
        empty_m = (q.size() == 0);
        g = -1;
        if (!(r || f || full_m)) begin
            if (r0 && r1) g = last ? 0 : 1;
            else if (r0)  g = 0;
            else if (r1)  g = 1;
        end
        re = p && !empty_m && !f && !r;

        check("gnt0", gnt0, g == 0);
        check("gnt1", gnt1, g == 1);
        check("writeEnable", writeEnable, g >= 0);
        check("readEnable", readEnable, re);
        check("wd", wd, (g == 1) ? d1 : d0);
        check("full", full, full_m);
        check("empty", empty, empty_m);
        check("count", count, q.size());
        check("wptr", wptr, wp % 64);
        check("rptr", rptr, rp % 64);
        check("rvalid", rvalid, rv_pend && !r);
        if (rv_pend && !r) check("rd", rd, rd_exp);

        if (r) begin
            q.delete(); wp = 0; rp = 0; last = 1'b1; rv_pend = 1'b0;
        end else if (f) begin
            q.delete(); wp = 0; rp = 0; rv_pend = 1'b0;
        end else begin
            if (re) begin
                rd_exp = q.pop_front();
                rp = (rp + 1) % 64;
            end
            if (g >= 0) begin
                q.push_back((g == 1) ? d1 : d0);
                wp = (wp + 1) % 64;
                last = (g == 1);
            end
            rv_pend = re;
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, '0, '0, 0);
        step(1, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, base + i, $urandom, 0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom, $urandom, 1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; req0 = 1'b0; req1 = 1'b0; pop = 1'b0;
        wd0 = '0; wd1 = '0;
        q.delete(); wp = 0; rp = 0; last = 1'b1; rv_pend = 1'b0; rd_exp = '0;

        // fill with 1..32 from req0 alone, 33rd request blocked, then drain
        do_reset();
        push_n(33, 1);
        pop_n(33);

        // continuous tie from reset: alternating grants, interleaved data
        do_reset();
        for (int i = 0; i < 34; i++) step(0, 0, 1, 1, 32'h100 + i, 32'h200 + i, 0);
        pop_n(33);

        // three full laps to wrap pointers through 63 -> 0
        for (int lap = 0; lap < 3; lap++) begin
            push_n(32, 1000 * (lap + 1));
            pop_n(32);
        end

        // steady push+pop at count 10, then at full
        push_n(10, 500);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 600 + i, 0, 1);
        push_n(22, 700);
        step(0, 0, 1, 1, 32'hdead, 32'hbeef, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        pop_n(32);

        // flush at count 7 keeps arbiter priority
        do_reset();
        step(0, 0, 1, 1, 1, 2, 0);
        push_n(6, 10);
        step(0, 1, 1, 1, 3, 4, 1);
        step(0, 0, 1, 1, 5, 6, 0);
        step(0, 0, 1, 1, 7, 8, 1);

        // reset the cycle after a read: in-flight rvalid suppressed
        push_n(3, 20);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 1, 9, 9, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // random traffic with varying producer/consumer bias
        for (int blk = 0; blk < 12; blk++) begin
            int unsigned pth, wth;
            pth = $urandom_range(10, 90);
            wth = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < wth, $urandom_range(0, 99) < wth,
                     $urandom, $urandom, $urandom_range(0, 99) < pth);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
